// File: rtl/sklansky_subtractor_pipe_if.sv
// Operand/result handshake bundle for the pipelined Sklansky subtractor.
// The master side issues operand pairs and accepts results; the slave side
// is the subtractor itself.
interface sklansky_subtractor_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_diff, out_borrow, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_diff, out_borrow, out_ovf, out_zero
    );
endinterface

// File: rtl/sklansky_subtractor_pipe.sv
// Three-stage pipelined A - B (computed as A + ~B + 1) using a Sklansky
// prefix carry network padded to the next power of two. The lower half of
// the prefix levels sits between S1 and S2, the rest plus the sum and flag
// logic between S2 and S3. Every stage has its own valid bit so bubbles
// collapse under backpressure.
module sklansky_subtractor_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    sklansky_subtractor_pipe_if.slave   bus
);
    localparam int LVLS = $clog2(WIDTH);
    localparam int N    = 1 << LVLS;
    localparam int LO   = (LVLS + 1) / 2;

    logic             v1, v2, v3;
    logic             adv1, adv2, adv3;

    logic [N-1:0]     p_pad, g_pad;
    logic [N-1:0]     s1_p, s1_g;
    logic             s1_a_msb, s1_b_msb;

    logic [N-1:0]     s2_p, s2_g;
    logic [WIDTH-1:0] s2_p_bits;
    logic             s2_a_msb, s2_b_msb;

    logic [N-1:0]     final_g, final_p;
    logic [WIDTH-1:0] carry, diff;
    logic             borrow, ovf, zero;

    logic [WIDTH-1:0] out_diff_q;
    logic             out_borrow_q, out_ovf_q, out_zero_q;

    logic             unused_bits;

    // Stage advance chain: a stage moves on when empty or when its successor moves.
    always_comb begin
        adv3 = ~v3 | bus.out_ready;
        adv2 = ~v2 | adv3;
        adv1 = ~v1 | adv2;
    end

    assign bus.in_ready = adv1 & ~rst;

    // Valid bits; reset discards anything in flight.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so each stage samples its predecessor's pre-edge value.
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= bus.in_valid;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
        end
    end

    // Bitwise propagate/generate of A + ~B, carry-in folded into bit 0, padded to N.
    always_comb begin
        // NOTE: every variable gets a full default first so no latch is inferred.
        p_pad = '0;
        g_pad = '0;
        p_pad[WIDTH-1:0] = bus.in_a ^ ~bus.in_b;
        g_pad[WIDTH-1:0] = bus.in_a & ~bus.in_b;
        g_pad[0]         = g_pad[0] | p_pad[0];
    end

    // S1 register: propagate/generate and operand sign bits.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; only valid bits and visible outputs need one.
        if (adv1) begin
            s1_p     <= p_pad;
            s1_g     <= g_pad;
            s1_a_msb <= bus.in_a[WIDTH-1];
            s1_b_msb <= bus.in_b[WIDTH-1];
        end
    end

    // Sklansky levels: at level l, bit i with bit l set absorbs the group
    // ending just below its 2^l-aligned block.
    for (genvar l = 0; l < LVLS; l++) begin : lvl
        logic [N-1:0] g_i, p_i, g_o, p_o;
        if (l == 0) begin : src_s1
            assign g_i = s1_g;
            assign p_i = s1_p;
        end else if (l == LO) begin : src_s2
            assign g_i = s2_g;
            assign p_i = s2_p;
        end else begin : src_prev
            assign g_i = lvl[l-1].g_o;
            assign p_i = lvl[l-1].p_o;
        end
        for (genvar i = 0; i < N; i++) begin : bitn
            if (((i >> l) & 1) == 1) begin : merge
                localparam int J = ((i >> l) << l) - 1;
                assign g_o[i] = g_i[i] | (p_i[i] & g_i[J]);
                assign p_o[i] = p_i[i] & p_i[J];
            end else begin : pass
                assign g_o[i] = g_i[i];
                assign p_o[i] = p_i[i];
            end
        end
    end

    // S2 register: partial prefix result plus the raw propagate bits for the sum.
    always_ff @(posedge clk) begin
        if (adv2) begin
            s2_g      <= lvl[LO-1].g_o;
            s2_p      <= lvl[LO-1].p_o;
            s2_p_bits <= s1_p[WIDTH-1:0];
            s2_a_msb  <= s1_a_msb;
            s2_b_msb  <= s1_b_msb;
        end
    end

    if (LO == LVLS) begin : fin_s2
        assign final_g = s2_g;
        assign final_p = s2_p;
    end else begin : fin_lvl
        assign final_g = lvl[LVLS-1].g_o;
        assign final_p = lvl[LVLS-1].p_o;
    end

    // Upper padding of the tree and the group propagates are not needed past here.
    assign unused_bits = ^{final_g, final_p, s2_p};

    // Sum and flags; c[0] is the carry-in, c[i] the group generate of bits [i-1:0].
    always_comb begin
        carry  = {final_g[WIDTH-2:0], 1'b1};
        diff   = s2_p_bits ^ carry;
        borrow = ~final_g[WIDTH-1];
        ovf    = (s2_a_msb ^ s2_b_msb) & (diff[WIDTH-1] ^ s2_a_msb);
        zero   = ~|diff;
    end

    // S3 register: drives the outputs directly and holds them while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_diff_q   <= '0;
            out_borrow_q <= 1'b0;
            out_ovf_q    <= 1'b0;
            out_zero_q   <= 1'b0;
        end else if (adv3) begin
            out_diff_q   <= diff;
            out_borrow_q <= borrow;
            out_ovf_q    <= ovf;
            out_zero_q   <= zero;
        end
    end

    assign bus.out_valid  = v3;
    assign bus.out_diff   = out_diff_q;
    assign bus.out_borrow = out_borrow_q;
    assign bus.out_ovf    = out_ovf_q;
    assign bus.out_zero   = out_zero_q;
endmodule
